// File: rtl/mesi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mesi_pkg
//  Description : Shared definitions for the MESI snoop-bus controller:
//                line-state encoding, controller state enum and a helper
//                that tells whether a line state holds valid data.
//  Revision    : 1.0  initial release
// ============================================================================
package mesi_pkg;

  // Line-state encoding as presented by each core's MESI FSM
  localparam logic [1:0] M = 2'b00;
  localparam logic [1:0] E = 2'b01;
  localparam logic [1:0] S = 2'b11;
  localparam logic [1:0] I = 2'b10;

  // Bus controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // A line holds data in every state except Invalid
  function automatic logic is_valid(input logic [1:0] state);
    return (state != I);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mesi_bus_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting at the pointer position and returns the
//                first requester as a one-hot grant plus its index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // One bit wider than the index so ptr+i can wrap without overflow
  localparam int PW = IW + 1;

  logic [PW-1:0] pos;
  logic          found;

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the first
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
    grant[idx] = found;
    valid      = found;
  end

endmodule
`default_nettype wire

// File: rtl/mesi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mesi_bus_ctrl
//  Description : Snoop-bus controller in front of NCORES MESI FSMs. Grants
//                one read/write request at a time round-robin, broadcasts
//                the bus snoop to the other cores, then drives the
//                processor-side pulse and shared flag to the requester and
//                finally a one-cycle acknowledge.
//  Options     : MESI_BUS_SILENT_HIT_EN - reads that hit a valid line in the
//                requester skip the snoop/transfer and acknowledge at once.
//  Revision    : 1.0  initial release
// ============================================================================
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORES-1:0]     req_rd,
  input  logic [NCORES-1:0]     req_wr,
  input  logic [2*NCORES-1:0]   line_state,
  output logic [NCORES-1:0]     pr,
  output logic [NCORES-1:0]     pw,
  output logic [NCORES-1:0]     br,
  output logic [NCORES-1:0]     bw,
  output logic [NCORES-1:0]     s,
  output logic [NCORES-1:0]     ack,
  output logic                  busy
);

  localparam int IW = $clog2(NCORES);

  ctrl_state_e       state_q, state_d;
  logic [IW-1:0]     ptr_q,   ptr_d;
  logic [IW-1:0]     win_q,   win_d;
  logic              op_wr_q, op_wr_d;
  logic              sh_q,    sh_d;

  logic [NCORES-1:0] req_any;
  logic [NCORES-1:0] arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic              arb_is_wr;
  logic              others_valid;
  logic [NCORES-1:0] win_oh;

  assign req_any   = req_rd | req_wr;
  // A core raising both request lines is treated as a write
  assign arb_is_wr = |(req_wr & arb_grant);

  rr_arbiter #(
    .N  (NCORES),
    .IW (IW)
  ) u_arb (
    .req   (req_any),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One-hot decode of the registered winner
  for (genvar k = 0; k < NCORES; k++) begin : g_win_oh
    assign win_oh[k] = (win_q == IW'(k));
  end

  // Shared flag: does any core other than the winner hold the line
  always_comb begin
    others_valid = 1'b0;
    for (int j = 0; j < NCORES; j++) begin
      if ((win_q != IW'(j)) && is_valid(line_state[2*j +: 2])) begin
        others_valid = 1'b1;
      end
    end
  end

`ifdef MESI_BUS_SILENT_HIT_EN
  logic own_valid;
  assign own_valid = is_valid(line_state[{arb_idx, 1'b0} +: 2]);
`endif

  // Next-state, winner capture and pointer advance
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_wr_d = op_wr_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          op_wr_d = arb_is_wr;
          ptr_d   = (arb_idx == IW'(NCORES - 1)) ? '0 : arb_idx + IW'(1);
`ifdef MESI_BUS_SILENT_HIT_EN
          state_d = (!arb_is_wr && own_valid) ? DONE : SNOOP;
`else
          state_d = SNOOP;
`endif
        end
      end
      SNOOP: begin
        // Sampled before the snoop pulse downgrades the other lines
        sh_d    = others_valid;
        state_d = XFER;
      end
      XFER:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state, winner and op
  always_comb begin
    pr   = '0;
    pw   = '0;
    br   = '0;
    bw   = '0;
    s    = '0;
    ack  = '0;
    busy = (state_q != IDLE);
    case (state_q)
      SNOOP: begin
        if (op_wr_q) bw = ~win_oh;
        else         br = ~win_oh;
      end
      XFER: begin
        if (op_wr_q) begin
          pw = win_oh;
        end else begin
          pr = win_oh;
          s  = sh_q ? win_oh : '0;
        end
      end
      DONE:    ack = win_oh;
      default: ;
    endcase
  end

  // State registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_wr_q <= 1'b0;
      sh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_wr_q <= op_wr_d;
      sh_q    <= sh_d;
    end
  end

endmodule
`default_nettype wire
